vga_draw_scheduler: RTL and testbench

- Frame-level scheduler that shares the single VGA framebuffer write port (x, y, color, writeEn) between several drawing engines: background ROM copier, cursor sprite, score text.
- On each frame start (falling edge of V_SYNC), grants the port to every pending requester in turn, in ascending index order. Background therefore draws first and overlays draw later.
- Sits between the drawing engines and the VGA adapter. It replaces ad-hoc per-engine writeEn handling.

---
 rtl/vga_draw_scheduler_if.sv | 19 +
 rtl/vga_draw_scheduler.sv | 165 ++++++++++++++++
 tb/tb_vga_draw_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_draw_scheduler_if.sv
// vga_draw_scheduler_if: per-engine request/pixel bus plus the shared framebuffer write port.
interface vga_draw_scheduler_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0]   iReq;
  logic [NUM_REQ-1:0]   iDone;
  logic [NUM_REQ-1:0]   iPlot;
  logic [NUM_REQ*9-1:0] iX;
  logic [NUM_REQ*8-1:0] iY;
  logic [NUM_REQ*3-1:0] iColor;
  logic [NUM_REQ-1:0]   oGrant;
  logic [8:0]           x;
  logic [7:0]           y;
  logic [2:0]           color;
  logic                 writeEn;

  modport slave  (input  iReq, iDone, iPlot, iX, iY, iColor,
                  output oGrant, x, y, color, writeEn);
  modport master (output iReq, iDone, iPlot, iX, iY, iColor,
                  input  oGrant, x, y, color, writeEn);
endinterface

// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: per frame, grants the framebuffer write port to each latched requester in
// ascending index order. Optional raster clear pass before the grants: DRAW_SCHED_CLEAR_EN.
module vga_draw_scheduler #(
  parameter int         NUM_REQ     = 3,
  parameter int         TIMEOUT     = 131071,
  parameter int         XMAX        = 319,
  parameter int         YMAX        = 239,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic                clk,
  input  logic                iReset,
  input  logic                V_SYNC,
  input  logic                iClearErr,
  vga_draw_scheduler_if.slave bus,
  output logic                oBusy,
  output logic                oFrameDone,
  output logic                oTimeoutErr,
  output logic                oOverrun
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
`ifdef DRAW_SCHED_CLEAR_EN
  localparam logic [2:0] CLEAR  = 3'd1;
`endif
  localparam logic [2:0] SELECT = 3'd2;
  localparam logic [2:0] GRANT  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  if (XMAX > 511 || YMAX > 255 || NUM_REQ < 1 || TIMEOUT < 1 || $bits(CLEAR_COLOR) != 3) begin : g_bad_cfg
    $error("vga_draw_scheduler: parameter out of range");
  end

  logic [NUM_REQ-1:0][8:0] sx;
  logic [NUM_REQ-1:0][7:0] sy;
  logic [NUM_REQ-1:0][2:0] sc;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign sx[g] = bus.iX[9*g +: 9];
    assign sy[g] = bus.iY[8*g +: 8];
    assign sc[g] = bus.iColor[3*g +: 3];
  end

  // Synchroniser idles high so reset release never looks like a falling edge.
  logic [2:0] vs;
  logic       frame_start;

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      vs          <= 3'b111;
      frame_start <= 1'b0;
    end else begin
      vs          <= {vs[1:0], V_SYNC};
      frame_start <= vs[2] & ~vs[1];
    end
  end

  logic [2:0]         state;
  logic [NUM_REQ-1:0] pend;
  logic [TW-1:0]      timer;
  logic [IW-1:0]      cur, sel_idx;
`ifdef DRAW_SCHED_CLEAR_EN
  logic [8:0]         cx;
  logic [7:0]         cy;
`endif

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (pend[i]) sel_idx = IW'(i);
  end

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      state       <= IDLE;
      pend        <= '0;
      timer       <= '0;
      cur         <= '0;
      bus.oGrant  <= '0;
      bus.x       <= '0;
      bus.y       <= '0;
      bus.color   <= '0;
      bus.writeEn <= 1'b0;
      oBusy       <= 1'b0;
      oFrameDone  <= 1'b0;
      oTimeoutErr <= 1'b0;
      oOverrun    <= 1'b0;
`ifdef DRAW_SCHED_CLEAR_EN
      cx          <= '0;
      cy          <= '0;
`endif
    end else begin
      oFrameDone  <= 1'b0;
      bus.writeEn <= 1'b0;
      // Set events are written after the clear so they take priority.
      if (iClearErr) begin
        oTimeoutErr <= 1'b0;
        oOverrun    <= 1'b0;
      end
      if (frame_start && oBusy) oOverrun <= 1'b1;

      case (state)
        IDLE: if (frame_start) begin
          pend  <= bus.iReq;
          oBusy <= 1'b1;
`ifdef DRAW_SCHED_CLEAR_EN
          cx    <= '0;
          cy    <= '0;
          state <= CLEAR;
`else
          state <= SELECT;
`endif
        end
`ifdef DRAW_SCHED_CLEAR_EN
        CLEAR: begin
          bus.writeEn <= 1'b1;
          bus.x       <= cx;
          bus.y       <= cy;
          bus.color   <= CLEAR_COLOR;
          if (cx == 9'(XMAX)) begin
            cx <= '0;
            if (cy == 8'(YMAX)) state <= SELECT;
            else                cy    <= cy + 8'd1;
          end else begin
            cx <= cx + 9'd1;
          end
        end
`endif
        SELECT: if (pend == '0) begin
          oFrameDone <= 1'b1;
          state      <= DONE;
        end else begin
          cur        <= sel_idx;
          bus.oGrant <= NUM_REQ'(1) << sel_idx;
          timer      <= '0;
          state      <= GRANT;
        end
        GRANT: begin
          bus.x       <= sx[cur];
          bus.y       <= sy[cur];
          bus.color   <= sc[cur];
          bus.writeEn <= bus.iPlot[cur];
          if (bus.iDone[cur]) begin
            pend[cur]  <= 1'b0;
            bus.oGrant <= '0;
            state      <= SELECT;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            pend[cur]   <= 1'b0;
            bus.oGrant  <= '0;
            oTimeoutErr <= 1'b1;
            state       <= SELECT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_draw_scheduler.sv
// tb_vga_draw_scheduler: scenario tasks plus randomized frames checked against an in-order service model.
module tb_vga_draw_scheduler;
  localparam int N  = 3;
  localparam int TO = 16;
`ifdef DRAW_SCHED_CLEAR_EN
  localparam int CLR = 8;
`else
  localparam int CLR = 0;
`endif

  logic clk = 1'b0, iReset = 1'b0, V_SYNC = 1'b1, iClearErr = 1'b0;
  logic oBusy, oFrameDone, oTimeoutErr, oOverrun;
  logic [N-1:0] gacc;
  int checks = 0, errors = 0;

  vga_draw_scheduler_if #(.NUM_REQ(N)) bus();

  vga_draw_scheduler #(.NUM_REQ(N), .TIMEOUT(TO), .XMAX(3), .YMAX(1), .CLEAR_COLOR(3'b000)) dut (
    .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .iClearErr(iClearErr), .bus(bus),
    .oBusy(oBusy), .oFrameDone(oFrameDone), .oTimeoutErr(oTimeoutErr), .oOverrun(oOverrun));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
    gacc |= bus.oGrant;
  endtask

  task automatic idle_inputs();
    bus.iReq = '0; bus.iDone = '0; bus.iPlot = '0;
    bus.iX = '0; bus.iY = '0; bus.iColor = '0;
    iClearErr = 1'b0;
  endtask

  task automatic vsync_pulse();
    V_SYNC = 1'b0;
    repeat (3) tick();
    V_SYNC = 1'b1;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 40 + CLR; i++) begin
      tick();
      if (bus.oGrant !== '0) begin g = bus.oGrant; return; end
`ifndef DRAW_SCHED_CLEAR_EN
      checks++; if (bus.writeEn !== 1'b0) begin errors++; $display("FAIL idle_we got %b want 0", bus.writeEn); end
`endif
    end
  endtask

  task automatic wait_fdone(output int cyc);
    cyc = -1;
    for (int i = 0; i < 40 + CLR; i++) begin
      tick();
      if (oFrameDone === 1'b1) begin cyc = i; return; end
    end
  endtask

  task automatic test_reset();
    iReset = 1'b0; idle_inputs();
    #3;
    checks++;
    if ({bus.oGrant, bus.x, bus.y, bus.color, bus.writeEn, oBusy, oFrameDone, oTimeoutErr, oOverrun} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b want 0",
        {bus.oGrant, bus.x, bus.y, bus.color, bus.writeEn, oBusy, oFrameDone, oTimeoutErr, oOverrun});
    end
    tick(); tick();
    iReset = 1'b1;
    tick();
  endtask

  task automatic test_sequence();
    logic [N-1:0] g; int cyc;
    idle_inputs(); gacc = '0;
    bus.iReq = 3'b101;
    vsync_pulse();
    wait_grant(g);
    checks++; if (g !== 3'b001) begin errors++; $display("FAIL seq_grant0 got %b want 001", g); end
    tick(); tick();
    bus.iDone = 3'b001; tick(); bus.iDone = '0;
    checks++; if (bus.oGrant !== 3'b000) begin errors++; $display("FAIL seq_release0 got %b want 000", bus.oGrant); end
    wait_grant(g);
    checks++; if (g !== 3'b100) begin errors++; $display("FAIL seq_grant2 got %b want 100", g); end
    bus.iDone = 3'b100; tick(); bus.iDone = '0;
    wait_fdone(cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL seq_framedone got timeout want pulse"); end
    tick();
    checks++; if (oBusy !== 1'b0 || oFrameDone !== 1'b0) begin
      errors++; $display("FAIL seq_idle got busy=%b fd=%b want 0 0", oBusy, oFrameDone); end
    checks++; if (gacc !== 3'b101) begin errors++; $display("FAIL seq_granted_set got %b want 101", gacc); end
  endtask

  task automatic test_datapath();
    logic [N-1:0] g; int cyc;
    idle_inputs();
    bus.iReq = 3'b010;
    vsync_pulse();
    wait_grant(g);
    checks++; if (g !== 3'b010) begin errors++; $display("FAIL dp_grant got %b want 010", g); end
    bus.iX = {9'd0, 9'd17, 9'd300}; bus.iY = {8'd0, 8'd42, 8'd7}; bus.iColor = {3'd0, 3'd5, 3'd2};
    bus.iPlot = 3'b011;
    tick();
    checks++;
    if ({bus.x, bus.y, bus.color, bus.writeEn} !== {9'd17, 8'd42, 3'd5, 1'b1}) begin
      errors++; $display("FAIL dp_port got x=%0d y=%0d c=%0d we=%b want 17 42 5 1", bus.x, bus.y, bus.color, bus.writeEn); end
    bus.iPlot = 3'b001; bus.iDone = 3'b001;
    tick();
    checks++; if (bus.writeEn !== 1'b0) begin errors++; $display("FAIL dp_ignore_plot got %b want 0", bus.writeEn); end
    checks++; if (bus.oGrant !== 3'b010) begin errors++; $display("FAIL dp_ignore_done got %b want 010", bus.oGrant); end
    bus.iPlot = '0; bus.iDone = 3'b010; tick(); bus.iDone = '0;
    wait_fdone(cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL dp_framedone got timeout want pulse"); end
    tick();
  endtask

  task automatic test_timeout();
    logic [N-1:0] g; int cyc;
    idle_inputs();
    bus.iReq = 3'b011;
    vsync_pulse();
    wait_grant(g);
    checks++; if (g !== 3'b001) begin errors++; $display("FAIL to_grant0 got %b want 001", g); end
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (i < TO) begin
        checks++; if (bus.oGrant !== 3'b001) begin errors++; $display("FAIL to_hold%0d got %b want 001", i, bus.oGrant); end
      end else begin
        checks++; if ({bus.oGrant, oTimeoutErr} !== 4'b0001) begin
          errors++; $display("FAIL to_revoke got g=%b err=%b want 000 1", bus.oGrant, oTimeoutErr); end
      end
    end
    tick();
    checks++; if (bus.oGrant !== 3'b010) begin errors++; $display("FAIL to_next got %b want 010", bus.oGrant); end
    bus.iDone = 3'b010; tick(); bus.iDone = '0;
    wait_fdone(cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL to_framedone got timeout want pulse"); end
    tick();
    iClearErr = 1'b1; tick(); iClearErr = 1'b0;
    checks++; if (oTimeoutErr !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", oTimeoutErr); end
    // iDone on the expiry cycle must win.
    bus.iReq = 3'b001;
    vsync_pulse();
    wait_grant(g);
    repeat (TO - 1) tick();
    bus.iDone = 3'b001; tick(); bus.iDone = '0;
    checks++; if ({bus.oGrant, oTimeoutErr} !== 4'b0000) begin
      errors++; $display("FAIL to_coincide got g=%b err=%b want 000 0", bus.oGrant, oTimeoutErr); end
    wait_fdone(cyc);
    tick();
  endtask

  task automatic test_overrun();
    logic [N-1:0] g; int cyc;
    idle_inputs(); gacc = '0;
    bus.iReq = 3'b011;
    vsync_pulse();
    wait_grant(g);
    bus.iReq = 3'b111;
    vsync_pulse();
    repeat (3) tick();
    checks++; if (oOverrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", oOverrun); end
    checks++; if (bus.oGrant !== 3'b001) begin errors++; $display("FAIL ovr_no_restart got %b want 001", bus.oGrant); end
    bus.iDone = 3'b001; tick(); bus.iDone = '0;
    wait_grant(g);
    checks++; if (g !== 3'b010) begin errors++; $display("FAIL ovr_grant1 got %b want 010", g); end
    bus.iDone = 3'b010; tick(); bus.iDone = '0;
    wait_fdone(cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL ovr_framedone got timeout want pulse"); end
    repeat (8) tick();
    checks++; if ({oBusy, gacc} !== 4'b0011) begin
      errors++; $display("FAIL ovr_dropped got busy=%b granted=%b want 0 011", oBusy, gacc); end
    vsync_pulse();
    for (int k = 0; k < N; k++) begin
      wait_grant(g);
      checks++; if (g !== N'(1 << k)) begin errors++; $display("FAIL late_grant%0d got %b want %b", k, g, N'(1 << k)); end
      bus.iDone = N'(1 << k); tick(); bus.iDone = '0;
    end
    wait_fdone(cyc);
    tick();
    iClearErr = 1'b1; tick(); iClearErr = 1'b0;
    checks++; if (oOverrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", oOverrun); end
  endtask

  task automatic test_empty();
    int first, writes;
    idle_inputs();
    first = -1; writes = 0;
    V_SYNC = 1'b0;
    for (int t = 1; t <= 12 + CLR; t++) begin
      tick();
      if (t == 3) V_SYNC = 1'b1;
      if (bus.writeEn === 1'b1) writes++;
      if (oFrameDone === 1'b1 && first < 0) first = t;
    end
    checks++; if (first !== 5 + CLR) begin errors++; $display("FAIL empty_latency got %0d want %0d", first, 5 + CLR); end
    checks++; if (writes !== CLR) begin errors++; $display("FAIL empty_writes got %0d want %0d", writes, CLR); end
  endtask

`ifdef DRAW_SCHED_CLEAR_EN
  task automatic test_clear();
    logic [19:0] seen[$];
    int gwrites, cyc;
    idle_inputs(); gwrites = 0;
    bus.iReq = 3'b001;
    V_SYNC = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 3) V_SYNC = 1'b1;
      if (bus.oGrant !== '0) break;
      if (bus.writeEn === 1'b1) seen.push_back({bus.x, bus.y, bus.color});
    end
    checks++; if (seen.size() !== 8) begin errors++; $display("FAIL clr_count got %0d want 8", seen.size()); end
    for (int yy = 0; yy <= 1; yy++)
      for (int xx = 0; xx <= 3; xx++) begin
        if (yy * 4 + xx < seen.size()) begin
          checks++;
          if (seen[yy * 4 + xx] !== {9'(xx), 8'(yy), 3'b000}) begin
            errors++; $display("FAIL clr_pixel%0d got %h want %h", yy * 4 + xx, seen[yy * 4 + xx], {9'(xx), 8'(yy), 3'b000}); end
        end
      end
    checks++; if (bus.oGrant !== 3'b001) begin errors++; $display("FAIL clr_then_grant got %b want 001", bus.oGrant); end
    bus.iDone = 3'b001; tick(); bus.iDone = '0;
    wait_fdone(cyc);
    tick();
  endtask
`endif

  task automatic test_random_frames();
    logic [N-1:0] req, g;
    logic [8:0] ex; logic [7:0] ey; logic [2:0] ec; logic ew;
    int n, cyc;
    for (int f = 0; f < 8; f++) begin
      idle_inputs();
      req = N'($urandom_range(1, 7));
      bus.iReq = req;
      vsync_pulse();
      for (int k = 0; k < N; k++) begin
        if (!req[k]) continue;
        wait_grant(g);
        checks++; if (g !== N'(1 << k)) begin errors++; $display("FAIL rnd_f%0d_order got %b want %b", f, g, N'(1 << k)); end
        n = $urandom_range(1, 6);
        for (int c = 0; c < n; c++) begin
          bus.iX = 27'($urandom); bus.iY = 24'($urandom); bus.iColor = 9'($urandom);
          bus.iPlot = N'($urandom);
          bus.iDone = (c == n - 1) ? N'(1 << k) : (N'($urandom) & ~N'(1 << k));
          ex = bus.iX[9*k +: 9]; ey = bus.iY[8*k +: 8]; ec = bus.iColor[3*k +: 3]; ew = bus.iPlot[k];
          tick();
          checks++;
          if ({bus.x, bus.y, bus.color, bus.writeEn} !== {ex, ey, ec, ew}) begin
            errors++; $display("FAIL rnd_f%0d_port got %0d,%0d,%0d,%b want %0d,%0d,%0d,%b",
              f, bus.x, bus.y, bus.color, bus.writeEn, ex, ey, ec, ew); end
          checks++;
          if (bus.oGrant !== ((c == n - 1) ? N'(0) : N'(1 << k))) begin
            errors++; $display("FAIL rnd_f%0d_hold got %b req %0d cyc %0d", f, bus.oGrant, k, c); end
        end
        bus.iDone = '0; bus.iPlot = '0;
      end
      wait_fdone(cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL rnd_f%0d_framedone got timeout want pulse", f); end
      tick();
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [N-1:0] g;
    idle_inputs();
    bus.iReq = 3'b001;
    vsync_pulse();
    wait_grant(g);
    bus.iPlot = 3'b001;
    tick();
    #2 iReset = 1'b0;
    #1;
    checks++; if ({bus.oGrant, bus.writeEn, oBusy} !== 5'b0) begin
      errors++; $display("FAIL async_reset got g=%b we=%b busy=%b want 0", bus.oGrant, bus.writeEn, oBusy); end
    idle_inputs();
    tick();
    iReset = 1'b1;
    tick();
  endtask

  initial begin
    gacc = '0;
    test_reset();
    test_sequence();
    test_datapath();
    test_timeout();
    test_overrun();
    test_empty();
`ifdef DRAW_SCHED_CLEAR_EN
    test_clear();
`endif
    test_random_frames();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
